// File: rtl/ej32_pkg.sv
// eJ32 shared types, widths and opcode phase table.
// Phase count 0 marks an opcode the sequencer cannot run.
package ej32_pkg;
  localparam int DSZ = 32;
  localparam int ASZ = 17;

  typedef logic [7:0] opcode_t;
  typedef logic [2:0] u3_t;
  typedef enum logic [1:0] {FETCH, EXEC, HALT} seq_state_t;

  localparam opcode_t NOP_OP        = 8'h00;
  localparam opcode_t IFEQ_OP       = 8'h99;
  localparam opcode_t GOTO_OP       = 8'hA7;
  localparam opcode_t JSR_OP        = 8'hA8;
  localparam opcode_t INVOKEVIRT_OP = 8'hB6;
  localparam opcode_t IFNULL_OP     = 8'hC6;
  localparam opcode_t IFNONNULL_OP  = 8'hC7;
  localparam opcode_t JVM_LAST_OP   = 8'hC9;
  localparam opcode_t DONEXT_OP     = 8'hCA;

  // 0x99..0xA7 covers every if*/if_icmp*/if_acmp* branch plus goto
  function automatic u3_t op_phases(opcode_t op);
    u3_t n;
    n = 3'd1;
    if (op > JVM_LAST_OP && op != DONEXT_OP)
      n = 3'd0;
    else if (op == JSR_OP)
      n = 3'd3;
    else if ((op >= IFEQ_OP && op <= GOTO_OP)
             || op == INVOKEVIRT_OP
             || op == IFNULL_OP
             || op == IFNONNULL_OP
             || op == DONEXT_OP)
      n = 3'd2;
    return n;
  endfunction
endpackage

// File: rtl/ej32_seq_if.sv
// Sequencer bus: memory byte stream, unit TOS requests,
// branch target and the sequencer's control outputs.
interface ej32_seq_if;
  import ej32_pkg::*;

  logic [7:0]     data;
  logic           mem_rdy;
  logic [ASZ-1:0] br_p;
  logic           br_psel;
  logic [DSZ-1:0] br_t;
  logic           br_t_x;
  logic [DSZ-1:0] au_t;
  logic           au_t_x;
  logic [DSZ-1:0] ls_t;
  logic           ls_t_x;
  logic [7:0]     code;
  logic [2:0]     phase;
  logic [ASZ-1:0] p;
  logic           br_en;
  logic           au_en;
  logic           ls_en;
  logic [DSZ-1:0] t;
  logic           t_clash;
  logic           halt;

  modport master (
    input  data, mem_rdy, br_p, br_psel,
    input  br_t, br_t_x, au_t, au_t_x,
    input  ls_t, ls_t_x,
    output code, phase, p,
    output br_en, au_en, ls_en,
    output t, t_clash, halt
  );

  modport slave (
    output data, mem_rdy, br_p, br_psel,
    output br_t, br_t_x, au_t, au_t_x,
    output ls_t, ls_t_x,
    input  code, phase, p,
    input  br_en, au_en, ls_en,
    input  t, t_clash, halt
  );
endinterface

// File: rtl/ej32_tarb.sv
// TOS write-back arbiter: fixed priority br > au > ls,
// registered TOS and a sticky multi-request flag.
module ej32_tarb
  import ej32_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en_i,
  input  logic           br_x_i,
  input  logic           au_x_i,
  input  logic           ls_x_i,
  input  logic [DSZ-1:0] br_t_i,
  input  logic [DSZ-1:0] au_t_i,
  input  logic [DSZ-1:0] ls_t_i,
  output logic [DSZ-1:0] t_o,
  output logic           clash_o
);
  logic [DSZ-1:0] t_q, t_d;
  logic           clash_q, clash_d;
  logic           multi;

  assign multi = (br_x_i & au_x_i)
               | (br_x_i & ls_x_i)
               | (au_x_i & ls_x_i);

  always_comb begin
    t_d     = t_q;
    clash_d = clash_q;
    if (en_i) begin
      priority case (1'b1)
        br_x_i:  t_d = br_t_i;
        au_x_i:  t_d = au_t_i;
        ls_x_i:  t_d = ls_t_i;
        default: t_d = t_q;
      endcase
      if (multi)
        clash_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_q     <= '0;
      clash_q <= 1'b0;
    end else begin
      t_q     <= t_d;
      clash_q <= clash_d;
    end
  end

  assign t_o     = t_q;
  assign clash_o = clash_q;
endmodule

// File: rtl/ej32_seq.sv
// eJ32 instruction sequencer: opcode fetch, phase stepping,
// instruction pointer and unit enables.
module ej32_seq
  import ej32_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  ej32_seq_if.master bus
);
  seq_state_t     state_q, state_d;
  opcode_t        code_q, code_d;
  u3_t            phase_q, phase_d;
  logic [ASZ-1:0] p_q, p_d;
  logic [ASZ-1:0] fa;
  logic           en;

  // branch target only steers the fetch, never an operand read
  assign fa = bus.br_psel ? bus.br_p : p_q;
  assign en = (state_q == EXEC) && bus.mem_rdy;

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    phase_d = phase_q;
    p_d     = p_q;
    unique case (state_q)
      FETCH: begin
        if (bus.mem_rdy) begin
          code_d  = bus.data;
          phase_d = 3'd0;
          p_d     = fa + ASZ'(1);
          state_d = (op_phases(bus.data) == 3'd0)
                  ? HALT : EXEC;
        end
      end
      EXEC: begin
        if (en) begin
          if (phase_q < op_phases(code_q) - 3'd1) begin
            phase_d = phase_q + 3'd1;
            p_d     = p_q + ASZ'(1);
          end else begin
            state_d = FETCH;
          end
        end
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH;
      code_q  <= NOP_OP;
      phase_q <= 3'd0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      phase_q <= phase_d;
      p_q     <= p_d;
    end
  end

  ej32_tarb u_tarb (
    .clk     (clk),
    .rst_n   (rst),
    .en_i    (en),
    .br_x_i  (bus.br_t_x),
    .au_x_i  (bus.au_t_x),
    .ls_x_i  (bus.ls_t_x),
    .br_t_i  (bus.br_t),
    .au_t_i  (bus.au_t),
    .ls_t_i  (bus.ls_t),
    .t_o     (bus.t),
    .clash_o (bus.t_clash)
  );

  assign bus.code  = code_q;
  assign bus.phase = phase_q;
  assign bus.p     = p_q;
  assign bus.br_en = en;
  assign bus.au_en = en;
  assign bus.ls_en = en;
  assign bus.halt  = (state_q == HALT);
endmodule
